// File: rtl/paddle_pkg.sv
// Shared types and constants for the per-player paddle controller.
package paddle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SLOW,
        FAST
    } state_t;

    localparam logic [7:0] FILTER_RESET = 8'd128;

    function automatic logic [7:0] center_pos(input int unsigned lo, input int unsigned hi);
        return 8'((lo + hi) / 2);
    endfunction

endpackage

// File: rtl/paddle_avg4.sv
// Strobe-driven 4-tap moving average of the raw analog paddle position.
module paddle_avg4
    import paddle_pkg::*;
(
    input  logic       clk,
    input  logic       _reset,
    input  logic       strobe,
    input  logic [7:0] pos,
    output logic [7:0] avg
);

    logic [7:0] taps [4];
    logic [9:0] sum;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            for (int unsigned i = 0; i < 4; i++) taps[i] <= FILTER_RESET;
        end else if (strobe) begin
            taps[0] <= pos;
            for (int unsigned i = 1; i < 4; i++) taps[i] <= taps[i-1];
        end
    end

    always_comb begin
        sum = {2'b00, taps[0]} + {2'b00, taps[1]} + {2'b00, taps[2]} + {2'b00, taps[3]};
        avg = sum[9:2];
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Converts one player's digital or analog controls into a per-frame paddle vpos.
module paddle_ctrl
    import paddle_pkg::*;
#(
    parameter int unsigned VPOS_MIN     = 16,
    parameter int unsigned VPOS_MAX     = 200,
    parameter int unsigned STEP_SLOW    = 2,
    parameter int unsigned STEP_FAST    = 6,
    parameter int unsigned ACCEL_FRAMES = 8
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       _v256,
    input  logic       _attract,
    input  logic       use_analog,
    input  logic       joy_up,
    input  logic       joy_down,
    input  logic       analog_strobe,
    input  logic [7:0] analog_pos,
    output logic [7:0] vpos,
    output logic       moving
);

    localparam logic [7:0]        MIN8   = 8'(VPOS_MIN);
    localparam logic [7:0]        MAX8   = 8'(VPOS_MAX);
    localparam logic signed [9:0] MIN_S  = 10'(VPOS_MIN);
    localparam logic signed [9:0] MAX_S  = 10'(VPOS_MAX);
    localparam logic [7:0]        SPAN   = 8'(VPOS_MAX - VPOS_MIN);
    localparam logic [7:0]        SLOW8  = 8'(STEP_SLOW);
    localparam logic [7:0]        FAST8  = 8'(STEP_FAST);
    localparam logic [8:0]        ACCEL9 = 9'(ACCEL_FRAMES);
    localparam logic [7:0]        CENTER = center_pos(VPOS_MIN, VPOS_MAX);

    state_t     state, state_cur, state_n;
    logic [7:0] cnt, cnt_cur, cnt_n;
    logic [8:0] cnt_inc;
    logic       v256_q, ua_q, tick;
    logic       dir_up, dir_dn, dir_act;
    logic [7:0] step, clamped, avg, analog_vpos, vpos_n;
    logic       moving_n;
    logic signed [9:0] delta, sum_s;
    logic [15:0] prod;

    paddle_avg4 u_avg (
        .clk    (clk),
        ._reset (_reset),
        .strobe (analog_strobe),
        .pos    (analog_pos),
        .avg    (avg)
    );

    assign tick    = v256_q & ~_v256;
    assign dir_up  = joy_up & ~joy_down;
    assign dir_dn  = joy_down & ~joy_up;
    assign dir_act = dir_up | dir_dn;

    // A mode switch discards speed history immediately, even between ticks.
    assign state_cur = (use_analog != ua_q) ? IDLE : state;
    assign cnt_cur   = (use_analog != ua_q) ? '0 : cnt;
    assign cnt_inc   = {1'b0, cnt_cur} + 9'd1;
    assign step      = (state_cur == FAST) ? FAST8 : SLOW8;

    always_comb begin
        delta = dir_up ? -$signed({2'b00, step}) : $signed({2'b00, step});
        sum_s = $signed({2'b00, vpos}) + delta;
        if (sum_s < MIN_S)      clamped = MIN8;
        else if (sum_s > MAX_S) clamped = MAX8;
        else                    clamped = sum_s[7:0];
        prod        = {8'b0, avg} * {8'b0, SPAN};
        analog_vpos = MIN8 + prod[15:8];
    end

    always_comb begin
        state_n  = state_cur;
        cnt_n    = cnt_cur;
        vpos_n   = vpos;
        moving_n = moving;
        if (tick) begin
            if (!_attract) begin
                state_n  = IDLE;
                cnt_n    = '0;
                moving_n = 1'b0;
            end else if (use_analog) begin
                state_n  = IDLE;
                cnt_n    = '0;
                vpos_n   = analog_vpos;
                moving_n = (analog_vpos != vpos);
            end else begin
                if (dir_act) begin
                    vpos_n = clamped;
                    case (state_cur)
                        IDLE: begin
                            cnt_n   = 8'd1;
                            state_n = (ACCEL9 <= 9'd1) ? FAST : SLOW;
                        end
                        SLOW: begin
                            cnt_n   = cnt_inc[7:0];
                            state_n = (cnt_inc >= ACCEL9) ? FAST : SLOW;
                        end
                        default: state_n = FAST;
                    endcase
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
                moving_n = (vpos_n != vpos);
            end
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state  <= IDLE;
            cnt    <= '0;
            v256_q <= 1'b1;
            ua_q   <= 1'b0;
            vpos   <= CENTER;
            moving <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            v256_q <= _v256;
            ua_q   <= use_analog;
            vpos   <= vpos_n;
            moving <= moving_n;
        end
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl against a frame-level reference model.
module tb_paddle_ctrl;

    localparam int VMIN = 16, VMAX = 200, SSLOW = 2, SFAST = 6, ACCEL = 8;

    logic       clk = 1'b0;
    logic       _reset, _v256, _attract, use_analog, joy_up, joy_down, analog_strobe;
    logic [7:0] analog_pos, vpos;
    logic       moving;

    always #5 clk = ~clk;

    paddle_ctrl #(
        .VPOS_MIN     (VMIN),
        .VPOS_MAX     (VMAX),
        .STEP_SLOW    (SSLOW),
        .STEP_FAST    (SFAST),
        .ACCEL_FRAMES (ACCEL)
    ) dut (
        .clk           (clk),
        ._reset        (_reset),
        ._v256         (_v256),
        ._attract      (_attract),
        .use_analog    (use_analog),
        .joy_up        (joy_up),
        .joy_down      (joy_down),
        .analog_strobe (analog_strobe),
        .analog_pos    (analog_pos),
        .vpos          (vpos),
        .moving        (moving)
    );

    typedef struct { int vpos; int mov; } exp_t;
    exp_t q[$];
    int   n_tests = 0, n_fail = 0;

    // Reference model: consecutive moving frames decide the speed
    int m_vpos, m_mov, m_frames;
    int m_taps[4];

    function automatic void model_reset();
        m_vpos = (VMIN + VMAX) / 2;
        m_mov = 0;
        m_frames = 0;
        foreach (m_taps[i]) m_taps[i] = 128;
    endfunction

    function automatic void model_shift(input int v);
        m_taps[3] = m_taps[2];
        m_taps[2] = m_taps[1];
        m_taps[1] = m_taps[0];
        m_taps[0] = v;
    endfunction

    function automatic void model_tick();
        int nv, d, avg;
        nv = m_vpos;
        if (!_attract) begin
            m_frames = 0;
            m_mov = 0;
        end else if (use_analog) begin
            avg = (m_taps[0] + m_taps[1] + m_taps[2] + m_taps[3]) / 4;
            nv = VMIN + (avg * (VMAX - VMIN)) / 256;
            m_frames = 0;
            m_mov = (nv != m_vpos);
        end else begin
            d = int'(joy_down) - int'(joy_up);
            if (d == 0) m_frames = 0;
            else begin
                m_frames++;
                nv = m_vpos + d * ((m_frames > ACCEL) ? SFAST : SSLOW);
                if (nv < VMIN) nv = VMIN;
                if (nv > VMAX) nv = VMAX;
            end
            m_mov = (nv != m_vpos);
        end
        m_vpos = nv;
        q.push_back('{vpos: m_vpos, mov: m_mov});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: tick edges pop the scoreboard, all other edges must hold the last frame value
    initial begin
        bit   vprev, t;
        exp_t e;
        vprev = 1'b1;
        forever begin
            @(posedge clk);
            t = vprev && !_v256 && _reset;
            vprev = _reset ? _v256 : 1'b1;
            #1;
            if (t) begin
                if (q.size() == 0) check("tick_without_expectation", 1, 0);
                else begin
                    e = q.pop_front();
                    check("tick_vpos", int'(vpos), e.vpos);
                    check("tick_moving", int'(moving), e.mov);
                end
            end else begin
                check("stable_vpos", int'(vpos), m_vpos);
                check("stable_moving", int'(moving), m_mov);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input int v);
        @(negedge clk);
        analog_strobe = 1'b1;
        analog_pos = 8'(v);
        model_shift(v);
        @(negedge clk);
        analog_strobe = 1'b0;
    endtask

    task automatic tick(input bit with_strobe = 1'b0, input int v = 0);
        @(negedge clk);
        _v256 = 1'b0;
        model_tick();
        if (with_strobe) begin
            analog_strobe = 1'b1;
            analog_pos = 8'(v);
            model_shift(v);
        end
        @(negedge clk);
        analog_strobe = 1'b0;
        cyc(2);
        _v256 = 1'b1;
        cyc(2);
    endtask

    task automatic set_analog(input bit b);
        if (b != use_analog) m_frames = 0;
        use_analog = b;
    endtask

    initial begin
        _reset = 1'b0; _v256 = 1'b1; _attract = 1'b1; use_analog = 1'b0;
        joy_up = 1'b0; joy_down = 1'b0; analog_strobe = 1'b0; analog_pos = '0;
        model_reset();
        cyc(3);
        check("reset_vpos", int'(vpos), 108);
        check("reset_moving", int'(moving), 0);
        _reset = 1'b1;

        repeat (3) tick();
        check("idle_vpos", int'(vpos), 108);

        joy_down = 1'b1;
        repeat (12) tick();
        check("down12_vpos", int'(vpos), 148);
        joy_down = 1'b0;
        tick();
        check("release_vpos", int'(vpos), 148);
        check("release_moving", int'(moving), 0);

        set_analog(1'b1);
        repeat (4) strobe(6);
        tick();
        check("analog_to_20", int'(vpos), 20);
        set_analog(1'b0);
        joy_up = 1'b1;
        repeat (3) tick();
        check("top_clamp_vpos", int'(vpos), 16);
        check("top_clamp_moving", int'(moving), 0);
        joy_down = 1'b1;
        tick();
        check("both_pressed", int'(vpos), 16);
        joy_up = 1'b0; joy_down = 1'b0;

        set_analog(1'b1);
        repeat (4) strobe(255);
        tick();
        check("analog_255", int'(vpos), 199);
        strobe(0); strobe(0); strobe(255); strobe(255);
        tick();
        check("analog_127", int'(vpos), 107);
        tick(1'b1, 200);
        check("strobe_on_tick_pre", int'(vpos), 107);
        tick();
        check("strobe_on_tick_post", int'(vpos), 143);

        set_analog(1'b0);
        joy_down = 1'b1;
        _attract = 1'b0;
        repeat (5) tick();
        check("attract_frozen", int'(vpos), 143);
        _attract = 1'b1;
        tick();
        check("attract_restart", int'(vpos), 145);

        joy_down = 1'b0; joy_up = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        #2 _reset = 1'b0;
        model_reset();
        #1;
        check("async_reset_vpos", int'(vpos), 108);
        check("async_reset_moving", int'(moving), 0);
        @(negedge clk);
        _reset = 1'b1;
        joy_up = 1'b0; joy_down = 1'b1;
        tick();
        check("post_reset_step", int'(vpos), 110);

        for (int f = 0; f < 150; f++) begin
            int ns;
            joy_up   = 1'($urandom_range(0, 1));
            joy_down = 1'($urandom_range(0, 1));
            _attract = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) set_analog(!use_analog);
            ns = $urandom_range(0, 3);
            for (int s = 0; s < ns; s++) strobe($urandom_range(0, 255));
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 255));
        end

        cyc(4);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
